// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    // Default line-address, line-data and counter widths.
    localparam int unsigned DEF_AW = 28;
    localparam int unsigned DEF_DW = 128;
    localparam int unsigned DEF_CW = 16;

    // Requester IDs; also the bit positions in the arbiter's req/gnt vectors.
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_D,
        REL
    } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the I-cache, D-cache and memory-side signals of the arbiter.
// master: the arbiter's view. slave: the surrounding caches and memory.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned CW = DEF_CW
);
    logic          i_read;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ready;

    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;

    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    logic [CW-1:0] i_cnt;
    logic [CW-1:0] d_cnt;

    modport master (
        input  i_read, i_addr,
        input  d_read, d_write, d_addr, d_wdata,
        input  mem_rdata, mem_ready,
        output i_rdata, i_ready, d_rdata, d_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        output i_cnt, d_cnt
    );

    modport slave (
        output i_read, i_addr,
        output d_read, d_write, d_addr, d_wdata,
        output mem_rdata, mem_ready,
        input  i_rdata, i_ready, d_rdata, d_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        input  i_cnt, d_cnt
    );

endinterface

// File: rtl/arb_rr2.sv
// Combinational two-input round-robin picker.
// last = ID of the previous winner; on a tie the other requester wins.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       valid
);

    // One-hot grant: a lone requester wins outright, a tie goes away from last.
    always_comb begin
        gnt        = '0;
        gnt[REQ_I] = req[REQ_I] & (~req[REQ_D] | (last == REQ_D));
        gnt[REQ_D] = req[REQ_D] & (~req[REQ_I] | (last == REQ_I));
        valid      = |req;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-refill memory port between the I-cache and D-cache.
// Round-robin grant, registered memory commands, combinational ready
// routing and saturating per-requester completion counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned CW = DEF_CW
)(
    input  logic          clk,
    input  logic          proc_reset,
    mem_arbiter_if.master bus
);

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] i_cnt_q, i_cnt_d;
    logic [CW-1:0] d_cnt_q, d_cnt_d;

    logic [1:0]    req;
    logic [1:0]    gnt;
    logic          gnt_valid;

    assign req[REQ_I] = bus.i_read;
    assign req[REQ_D] = bus.d_read | bus.d_write;

    arb_rr2 u_arb (
        .req   (req),
        .last  (last_q),
        .gnt   (gnt),
        .valid (gnt_valid)
    );

    // State register.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered memory command, round-robin history and counters.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            last_q  <= REQ_I;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            i_cnt_q <= '0;
            d_cnt_q <= '0;
        end else begin
            last_q  <= last_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            i_cnt_q <= i_cnt_d;
            d_cnt_q <= d_cnt_d;
        end
    end

    // Next state plus next values of the registered outputs.
    // Commands load on the grant edge and clear on the completion edge, so
    // they only ever change at a clock edge.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        i_cnt_d = i_cnt_q;
        d_cnt_d = d_cnt_q;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    if (gnt[REQ_D]) begin
                        state_d = GNT_D;
                        last_d  = REQ_D;
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                        wr_d    = bus.d_write;
                        rd_d    = ~bus.d_write;
                    end else begin
                        state_d = GNT_I;
                        last_d  = REQ_I;
                        addr_d  = bus.i_addr;
                        wr_d    = 1'b0;
                        rd_d    = 1'b1;
                    end
                end
            end
            GNT_I: begin
                if (bus.mem_ready) begin
                    state_d = REL;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    i_cnt_d = (i_cnt_q == '1) ? i_cnt_q : i_cnt_q + 1'b1;
                end
            end
            GNT_D: begin
                if (bus.mem_ready) begin
                    state_d = REL;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    d_cnt_d = (d_cnt_q == '1) ? d_cnt_q : d_cnt_q + 1'b1;
                end
            end
            REL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_read  = rd_q;
    assign bus.mem_write = wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_ready   = bus.mem_ready & (state_q == GNT_I);
    assign bus.d_ready   = bus.mem_ready & (state_q == GNT_D);
    assign bus.i_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
    assign bus.i_cnt     = i_cnt_q;
    assign bus.d_cnt     = d_cnt_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one slow-memory port between the instruction cache and the data cache, which each drive a 128-bit line-refill interface (`mem_read`/`mem_write`/`mem_addr[31:4]`/`mem_ready`). The block sits between the two cache miss ports and the single memory port below them. It picks one requester using round-robin arbitration, drives the memory with registered outputs, and routes the single-cycle `mem_ready` pulse back to the winner. It also keeps per-requester saturating transaction counters for performance readout.

## Interface
- `AW`, 28: line-address width (address bits 31:4).
- `DW`, 128: line data width.
- `CW`, 16: transaction counter width.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `proc_reset`  in  1  asynchronous, active-high reset.
- `i_read`  in  1  I-cache line-read request; held high until `i_ready`.
- `i_addr`  in  AW  I-cache line address.
- `i_rdata`  out  DW  read data to the I-cache (`mem_rdata` broadcast).
- `i_ready`  out  1  one-cycle completion pulse to the I-cache.
- `d_read`, `d_write`  in  1  D-cache read and write-back requests; held high until `d_ready`.
- `d_addr`  in  AW  D-cache line address.
- `d_wdata`  in  DW  D-cache write-back data.
- `d_rdata`  out  DW  read data to the D-cache (`mem_rdata` broadcast).
- `d_ready`  out  1  one-cycle completion pulse to the D-cache.
- `mem_read`, `mem_write`  out  1  registered memory commands.
- `mem_addr`  out  AW  registered memory address.
- `mem_wdata`  out  DW  registered memory write data.
- `mem_rdata`  in  DW  memory read data, valid while `mem_ready`=1.
- `mem_ready`  in  1  one-cycle completion pulse from memory.
- `i_cnt`, `d_cnt`  out  CW  completed transactions per requester; saturate at all-ones.

## Operation
- States:
  - IDLE: no transaction; memory outputs deasserted.
  - GNT_I: I-cache transaction active on the memory port.
  - GNT_D: D-cache transaction active on the memory port.
  - REL: one-cycle release gap after a completion.
- Request signals: `reqI` = `i_read`; `reqD` = `d_read` | `d_write`.
- IDLE transitions:
  - Only `reqI` → GNT_I.
  - Only `reqD` → GNT_D.
  - Both → the requester that is not `last` wins.
  - `last` updates to the winner on every grant and resets to I, so the first tie after reset goes to D.
- Loading on grant, in the same edge that enters GNT_x:
  - `mem_addr` gets the winner's address.
  - For D: `mem_wdata` gets `d_wdata`; if `d_write`=1 then `mem_write`=1 and `mem_read`=0 (write wins if both are set), else `mem_read`=1.
  - For I: `mem_read`=1, `mem_write`=0; `mem_wdata` keeps its old value.
- GNT_x: memory outputs are held stable until `mem_ready`=1. Requester deassertion during GNT_x is ignored; the transaction always completes.
- Completion: `x_ready` = `mem_ready` & (state==GNT_x), combinational. `i_rdata` = `d_rdata` = `mem_rdata` at all times. On that edge the state goes to REL, `mem_read`/`mem_write` are cleared, and `x_cnt` increments unless already saturated.
- REL → IDLE unconditionally. A `mem_ready` outside GNT_x is ignored: no ready pulse, no counter change.
- Reset (asynchronous, any state, including mid-transaction): state=IDLE, `last`=I, `mem_read`=`mem_write`=0, `mem_addr`=0, `mem_wdata`=0, `i_cnt`=`d_cnt`=0.
- Reset value of `i_ready`/`d_ready` is 0 (state is IDLE). The rdata outputs follow `mem_rdata`.

## Timing
- Request seen high in IDLE at edge t → `mem_read`/`mem_write` high from t+1.
- Memory asserts `mem_ready` in cycle k → `x_ready`=1 in cycle k (zero added latency). Memory commands are low from k+1 (REL). The state is IDLE at k+2. The next command can appear at k+3 at the earliest.
- Back-to-back minimum turnaround: 3 cycles between a `mem_ready` and the next command rising.
- Memory commands are glitch-free: they change only on clock edges or on reset.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state enum {IDLE, GNT_I, GNT_D, REL};
  - the `AW`/`DW`/`CW` defaults;
  - requester ID constants `REQ_I`=0, `REQ_D`=1.
- One sub-module, `arb_rr2`: a combinational two-input round-robin picker.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: `gnt` one-hot, `valid`.
- Counters stay inline in the top level.

## Test plan
- Reset, then `i_read`=1 with `i_addr`=28'h0000040 and memory latency 5 → `mem_read` high one cycle later with `mem_addr`=28'h0000040. `i_ready` pulses once and `i_rdata` equals `mem_rdata` (e.g. 128'hDEAD…BEEF). `i_cnt`=1.
- `i_read` and `d_read` rise in the same cycle → D is served first; I is granted in the IDLE cycle after REL. The next simultaneous tie goes to D again, because `last`=I after the I grant.
- D write-back: `d_write`=1, `d_addr`=28'h0000100, `d_wdata`=128'h1234… → `mem_write`=1, `mem_read`=0, `mem_wdata` matches. `d_ready` pulses and `d_cnt` increments.
- Spurious `mem_ready` while IDLE → no `i_ready`/`d_ready` pulse and no counter change.
- Assert `proc_reset` mid-GNT_D (before `mem_ready`) → on the same cycle `mem_read`/`mem_write`=0, `mem_addr`=0 and counters are 0. After release, a new request is granted normally.
- Force `d_cnt` to 16'hFFFF, then complete one more D transaction → `d_cnt` stays 16'hFFFF.
